opsum_post_proc: RTL and testbench

Output post-processing stage directly downstream of the conv_unit PSUM output. It takes 32-bit partial/final sums over a valid/ready handshake and applies optional bias add, optional ReLU, rounding right-shift requantisation and int8 saturation. It packs four int8 results per 32-bit word and issues GLB writes starting at BASE_OPSUM, driving the active-low WEB/BWEB strobes. One pass is one cfg_start-to-done sequence.

---
 rtl/opsum_post_proc.sv | 162 ++++++++++++++++
 tb/tb_opsum_post_proc.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opsum_post_proc.sv
`default_nettype none
// ============================================================================
// Module      : opsum_post_proc
// Description : Applies bias, ReLU, rounding requantisation and int8
//               saturation to PSUMs, then packs four bytes per GLB write.
// Revision    : 1.0 - initial release
// ============================================================================
module opsum_post_proc #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_start,
    input  logic [1:0]            cfg_flags,
    input  logic [DATA_WIDTH-1:0] cfg_bias,
    input  logic [4:0]            cfg_shift,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [CNT_WIDTH-1:0]  cfg_count,
    input  logic                  psum_valid,
    input  logic [DATA_WIDTH-1:0] psum_data,
    output logic                  psum_ready,
    output logic                  glb_write_valid,
    input  logic                  glb_write_ready,
    output logic [ADDR_WIDTH-1:0] glb_write_addr,
    output logic [DATA_WIDTH-1:0] glb_write_data,
    output logic                  WEB,
    output logic [DATA_WIDTH-1:0] BWEB,
    output logic                  busy,
    output logic                  done
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] c_ADDR_STEP = ADDR_WIDTH'(4);
    localparam logic [DATA_WIDTH-1:0] c_MASK_ALL  = '1;

    logic [1:0]            r_state;
    logic                  r_bias_en;
    logic                  r_relu_en;
    logic [DATA_WIDTH-1:0] r_bias;
    logic [4:0]            r_shift;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [CNT_WIDTH-1:0]  r_remaining;
    logic [1:0]            r_lane;
    logic [DATA_WIDTH-1:0] r_pack;
    logic [DATA_WIDTH-1:0] r_bweb;
    logic                  r_wvalid;

    logic                  w_accept;
    logic                  w_issue;
    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH:0]   w_relu;
    logic [DATA_WIDTH+1:0] w_ext;
    logic [DATA_WIDTH+1:0] w_round;
    logic [DATA_WIDTH+1:0] w_shifted;
    logic [7:0]            w_byte;
    logic [DATA_WIDTH-1:0] w_bweb_next;

    assign psum_ready = (r_state == c_ST_RUN) && !r_wvalid;
    assign w_accept   = psum_valid && psum_ready;
    assign w_issue    = w_accept && ((r_lane == 2'd3) || (r_remaining == CNT_WIDTH'(1)));

    // Widen by one bit before the bias add and one more before rounding so neither can wrap.
    assign w_sum   = {psum_data[DATA_WIDTH-1], psum_data}
                   + (r_bias_en ? {r_bias[DATA_WIDTH-1], r_bias} : '0);
    assign w_relu  = (r_relu_en && w_sum[DATA_WIDTH]) ? '0 : w_sum;
    assign w_ext   = {w_relu[DATA_WIDTH], w_relu};
    assign w_round = (r_shift != 5'd0) ? ((DATA_WIDTH+2)'(1) << (r_shift - 5'd1)) : '0;
    assign w_shifted = $signed(w_ext + w_round) >>> r_shift;

    always_comb begin
        w_byte = w_shifted[7:0];
        if (w_shifted[DATA_WIDTH+1] && !(&w_shifted[DATA_WIDTH+1:7])) begin
            w_byte = 8'h80;
        end else if (!w_shifted[DATA_WIDTH+1] && (|w_shifted[DATA_WIDTH+1:7])) begin
            w_byte = 8'h7F;
        end
    end

    // Lanes above the one being written now carry no data in this word.
    always_comb begin
        w_bweb_next = '0;
        case (r_lane)
            2'd0:    w_bweb_next = 32'hFFFF_FF00;
            2'd1:    w_bweb_next = 32'hFFFF_0000;
            2'd2:    w_bweb_next = 32'hFF00_0000;
            default: w_bweb_next = 32'h0000_0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_bias_en   <= 1'b0;
            r_relu_en   <= 1'b0;
            r_bias      <= '0;
            r_shift     <= '0;
            r_addr      <= '0;
            r_remaining <= '0;
            r_lane      <= '0;
            r_pack      <= '0;
            r_bweb      <= c_MASK_ALL;
            r_wvalid    <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (cfg_start) begin
                        r_bias_en   <= cfg_flags[0];
                        r_relu_en   <= cfg_flags[1];
                        r_bias      <= cfg_bias;
                        r_shift     <= cfg_shift;
                        r_addr      <= cfg_base_addr;
                        r_remaining <= cfg_count;
                        r_lane      <= '0;
                        r_pack      <= '0;
                        r_state     <= (cfg_count == '0) ? c_ST_DONE : c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    if (w_accept) begin
                        r_pack[{r_lane, 3'b000} +: 8] <= w_byte;
                        r_lane      <= r_lane + 2'd1;
                        r_remaining <= r_remaining - CNT_WIDTH'(1);
                        if (w_issue) begin
                            r_wvalid <= 1'b1;
                            r_bweb   <= w_bweb_next;
                        end
                    end else if (r_wvalid && glb_write_ready) begin
                        r_wvalid <= 1'b0;
                        r_addr   <= r_addr + c_ADDR_STEP;
                        r_pack   <= '0;
                        r_lane   <= '0;
                        r_bweb   <= c_MASK_ALL;
                        if (r_remaining == '0) begin
                            r_state <= c_ST_DONE;
                        end
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign glb_write_valid = r_wvalid;
    assign glb_write_addr  = r_addr;
    assign glb_write_data  = r_pack;
    assign WEB             = ~r_wvalid;
    assign BWEB            = r_bweb;
    assign busy            = (r_state == c_ST_RUN);
    assign done            = (r_state == c_ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_opsum_post_proc.sv
`default_nettype none
// ============================================================================
// Module      : tb_opsum_post_proc
// Description : Directed self-checking bench for opsum_post_proc.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_opsum_post_proc;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_start;
    logic [1:0]  cfg_flags;
    logic [31:0] cfg_bias;
    logic [4:0]  cfg_shift;
    logic [31:0] cfg_base_addr;
    logic [15:0] cfg_count;
    logic        psum_valid;
    logic [31:0] psum_data;
    logic        psum_ready;
    logic        glb_write_valid;
    logic        glb_write_ready;
    logic [31:0] glb_write_addr;
    logic [31:0] glb_write_data;
    logic        WEB;
    logic [31:0] BWEB;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int valid_cycles = 0;
    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];
    logic [31:0] q_bweb[$];
    logic        q_web[$];

    always #5 clk = ~clk;

    opsum_post_proc #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .cfg_start(cfg_start), .cfg_flags(cfg_flags), .cfg_bias(cfg_bias),
        .cfg_shift(cfg_shift), .cfg_base_addr(cfg_base_addr), .cfg_count(cfg_count),
        .psum_valid(psum_valid), .psum_data(psum_data), .psum_ready(psum_ready),
        .glb_write_valid(glb_write_valid), .glb_write_ready(glb_write_ready),
        .glb_write_addr(glb_write_addr), .glb_write_data(glb_write_data),
        .WEB(WEB), .BWEB(BWEB), .busy(busy), .done(done)
    );

    always @(negedge clk) begin
        if (glb_write_valid && glb_write_ready) begin
            q_addr.push_back(glb_write_addr);
            q_data.push_back(glb_write_data);
            q_bweb.push_back(BWEB);
            q_web.push_back(WEB);
        end
        if (glb_write_valid) valid_cycles++;
        if (done) done_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log;
        q_addr.delete();
        q_data.delete();
        q_bweb.delete();
        q_web.delete();
        done_cnt = 0;
        valid_cycles = 0;
    endtask

    task automatic start_pass(input logic [1:0] f, input logic [31:0] b, input logic [4:0] s,
                              input logic [31:0] base, input logic [15:0] n);
        cfg_flags = f;
        cfg_bias = b;
        cfg_shift = s;
        cfg_base_addr = base;
        cfg_count = n;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic send(input logic [31:0] v);
        bit ok = 1'b0;
        psum_valid = 1'b1;
        psum_data = v;
        for (int k = 0; k < 50 && !ok; k++) begin
            if (psum_ready) ok = 1'b1;
            tick();
        end
        psum_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout: psum %h never accepted, required accept within 50 cycles", v);
        end
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            if (done) seen = 1'b1;
            else tick();
        end
        if (seen) tick();
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_done_timeout: done=0, required done=1 within 60 cycles", name);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cfg_start = 1'b0; cfg_flags = '0; cfg_bias = '0; cfg_shift = '0;
        cfg_base_addr = '0; cfg_count = '0; psum_valid = 1'b0; psum_data = '0;
        glb_write_ready = 1'b1;
        tick(); tick();
        checks++;
        if ({psum_ready, glb_write_valid, WEB, busy, done} !== 5'b00100) begin
            errors++;
            $display("FAIL reset_ctrl: {rdy,val,web,busy,done}=%b, required 00100",
                     {psum_ready, glb_write_valid, WEB, busy, done});
        end
        checks++;
        if (BWEB !== 32'hFFFF_FFFF || glb_write_addr !== 32'h0 || glb_write_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: bweb=%h addr=%h data=%h, required ffffffff 0 0",
                     BWEB, glb_write_addr, glb_write_data);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_pack;
        clear_log();
        start_pass(2'b00, 32'd0, 5'd0, 32'h100, 16'd4);
        send(32'd1); send(32'd2); send(32'd3); send(32'd4);
        checks++;
        if (glb_write_valid !== 1'b1 || WEB !== 1'b0 || psum_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_latency: val=%b web=%b rdy=%b, required 1 0 0",
                     glb_write_valid, WEB, psum_ready);
        end
        tick();
        checks++;
        if (done !== 1'b1 || glb_write_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: done=%b val=%b, required 1 0", done, glb_write_valid);
        end
        tick();
        checks++;
        if (q_addr.size() != 1 || q_addr[0] !== 32'h100 || q_data[0] !== 32'h0403_0201 ||
            q_bweb[0] !== 32'h0 || q_web[0] !== 1'b0) begin
            errors++;
            $display("FAIL basic_write: n=%0d addr=%h data=%h bweb=%h, required 1 100 04030201 0",
                     q_addr.size(), q_addr[0], q_data[0], q_bweb[0]);
        end
        checks++;
        if (valid_cycles != 1 || done_cnt != 1 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_pulses: valid_cycles=%0d done_cnt=%0d, required 1 1",
                     valid_cycles, done_cnt);
        end
    endtask

    task automatic test_bias_relu_shift;
        clear_log();
        start_pass(2'b11, 32'd10, 5'd2, 32'h200, 16'd4);
        send(-32'sd50); send(32'd5); send(32'd1000); send(-32'sd3);
        wait_done("bias");
        checks++;
        if (q_data.size() != 1 || q_data[0] !== 32'h027F_0400 || q_addr[0] !== 32'h200) begin
            errors++;
            $display("FAIL bias_relu_data: n=%0d data=%h addr=%h, required 1 027f0400 200",
                     q_data.size(), q_data[0], q_addr[0]);
        end
    endtask

    task automatic test_partial_word;
        clear_log();
        start_pass(2'b00, 32'd0, 5'd0, 32'h300, 16'd6);
        send(32'd1); send(32'd2);
        // A second start while busy must not disturb the running pass.
        start_pass(2'b00, 32'd0, 5'd0, 32'h900, 16'd1);
        send(32'd3); send(32'd4); send(32'd5); send(32'd6);
        wait_done("partial");
        checks++;
        if (q_addr.size() != 2 || done_cnt != 1) begin
            errors++;
            $display("FAIL partial_count: writes=%0d dones=%0d, required 2 1", q_addr.size(), done_cnt);
        end
        checks++;
        if (q_addr[0] !== 32'h300 || q_data[0] !== 32'h0403_0201 || q_bweb[0] !== 32'h0) begin
            errors++;
            $display("FAIL partial_w0: addr=%h data=%h bweb=%h, required 300 04030201 0",
                     q_addr[0], q_data[0], q_bweb[0]);
        end
        checks++;
        if (q_addr[1] !== 32'h304 || q_data[1] !== 32'h0000_0605 || q_bweb[1] !== 32'hFFFF_0000) begin
            errors++;
            $display("FAIL partial_w1: addr=%h data=%h bweb=%h, required 304 00000605 ffff0000",
                     q_addr[1], q_data[1], q_bweb[1]);
        end
    endtask

    task automatic test_backpressure;
        clear_log();
        glb_write_ready = 1'b0;
        start_pass(2'b00, 32'd0, 5'd0, 32'h400, 16'd8);
        send(32'd1); send(32'd2); send(32'd3); send(32'd4);
        psum_valid = 1'b1;
        psum_data = 32'd5;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (psum_ready !== 1'b0 || glb_write_valid !== 1'b1 || glb_write_addr !== 32'h400 ||
                glb_write_data !== 32'h0403_0201 || BWEB !== 32'h0) begin
                errors++;
                $display("FAIL backpressure_hold c%0d: rdy=%b val=%b addr=%h data=%h bweb=%h, required 0 1 400 04030201 0",
                         c, psum_ready, glb_write_valid, glb_write_addr, glb_write_data, BWEB);
            end
            tick();
        end
        psum_valid = 1'b0;
        glb_write_ready = 1'b1;
        send(32'd5); send(32'd6); send(32'd7); send(32'd8);
        wait_done("backpressure");
        checks++;
        if (q_addr.size() != 2 || q_data[0] !== 32'h0403_0201 || q_addr[1] !== 32'h404 ||
            q_data[1] !== 32'h0807_0605) begin
            errors++;
            $display("FAIL backpressure_writes: n=%0d d0=%h a1=%h d1=%h, required 2 04030201 404 08070605",
                     q_addr.size(), q_data[0], q_addr[1], q_data[1]);
        end
    endtask

    task automatic test_neg_saturation;
        clear_log();
        start_pass(2'b00, 32'd0, 5'd1, 32'h500, 16'd4);
        send(-32'sd300); send(-32'sd3); send(32'd3); send(32'd255);
        wait_done("negsat");
        checks++;
        if (q_data.size() != 1 || q_data[0] !== 32'h7F02_FF80) begin
            errors++;
            $display("FAIL neg_saturation: n=%0d data=%h, required 1 7f02ff80", q_data.size(), q_data[0]);
        end
    endtask

    task automatic test_reset_midpass;
        clear_log();
        start_pass(2'b00, 32'd0, 5'd0, 32'h600, 16'd4);
        send(32'd1); send(32'd2);
        rst = 1'b1;
        tick();
        checks++;
        if ({psum_ready, glb_write_valid, WEB, busy, done} !== 5'b00100 || BWEB !== 32'hFFFF_FFFF ||
            glb_write_addr !== 32'h0 || glb_write_data !== 32'h0) begin
            errors++;
            $display("FAIL midpass_reset: ctrl=%b bweb=%h addr=%h data=%h, required 00100 ffffffff 0 0",
                     {psum_ready, glb_write_valid, WEB, busy, done}, BWEB, glb_write_addr, glb_write_data);
        end
        rst = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        checks++;
        if (q_addr.size() != 0 || done_cnt != 0) begin
            errors++;
            $display("FAIL midpass_abort: writes=%0d dones=%0d, required 0 0", q_addr.size(), done_cnt);
        end
        start_pass(2'b00, 32'd0, 5'd0, 32'h700, 16'd4);
        send(32'd9); send(32'd10); send(32'd11); send(32'd12);
        wait_done("restart");
        checks++;
        if (q_addr.size() != 1 || q_addr[0] !== 32'h700 || q_data[0] !== 32'h0C0B_0A09) begin
            errors++;
            $display("FAIL restart_write: n=%0d addr=%h data=%h, required 1 700 0c0b0a09",
                     q_addr.size(), q_addr[0], q_data[0]);
        end
    endtask

    task automatic test_zero_count;
        clear_log();
        start_pass(2'b00, 32'd0, 5'd0, 32'h800, 16'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_done: done=%b busy=%b, required 1 0", done, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL zero_pulse: done=%b, required 0", done);
        end
        tick(); tick();
        checks++;
        if (q_addr.size() != 0 || done_cnt != 1) begin
            errors++;
            $display("FAIL zero_nowrite: writes=%0d dones=%0d, required 0 1", q_addr.size(), done_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic_pack();
        test_bias_relu_shift();
        test_partial_word();
        test_backpressure();
        test_neg_saturation();
        test_reset_midpass();
        test_zero_count();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
